// File: rtl/fifo4x8_ctrl_if.sv
// Handshake and RAM bus bundle for the 4x8 FIFO controller.
// The slave side is the controller; the master side is the
// surrounding environment (producer, consumer and the 4x8 RAM).
interface fifo4x8_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             push_ready;
  logic             pop;
  logic             pop_ready;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic             full;
  logic             empty;
  logic [2:0]       count;
  logic [1:0]       ram_addr;
  logic             ram_r_w;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;

  modport slave (
    input  push, push_data, pop, ram_rdata,
    output push_ready, pop_ready, pop_data, pop_valid,
           full, empty, count, ram_addr, ram_r_w, ram_wdata
  );

  modport master (
    output push, push_data, pop, ram_rdata,
    input  push_ready, pop_ready, pop_data, pop_valid,
           full, empty, count, ram_addr, ram_r_w, ram_wdata
  );
endinterface

// File: rtl/fifo4x8_ctrl.sv
// 4-entry x 8-bit FIFO controller backed by an external 4x8 RAM.
// One RAM access per operation: IDLE accepts a handshake, WR or RD
// performs the single RAM cycle, then control returns to IDLE.
module fifo4x8_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  fifo4x8_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t           state, state_nxt;
  logic [1:0]       wptr, rptr;
  logic [2:0]       count;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             pop_valid_q;
  logic             is_full, is_empty;
  logic             push_rdy, pop_rdy;
  logic             push_acc, pop_acc;

  // Occupancy flags come from the counter alone; pointers can be equal
  // both when empty and when full.
  assign is_full  = (count == 3'd4);
  assign is_empty = (count == 3'd0);

  // State register; an asynchronous clear aborts any RAM access in flight.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake readiness; pop wins a simultaneous request.
  always_comb begin
    state_nxt = state;
    push_rdy  = 1'b0;
    pop_rdy   = 1'b0;
    push_acc  = 1'b0;
    pop_acc   = 1'b0;
    case (state)
      IDLE: begin
        pop_rdy  = ~is_empty;
        push_rdy = ~is_full & ~(bus.pop & ~is_empty);
        pop_acc  = bus.pop & pop_rdy;
        push_acc = bus.push & push_rdy;
        if (pop_acc)       state_nxt = RD;
        else if (push_acc) state_nxt = WR;
      end
      WR:      state_nxt = IDLE;
      RD:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointers, count and data registers; updates land at the end of the
  // RAM cycle so an aborted access leaves them untouched.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wptr        <= 2'd0;
      rptr        <= 2'd0;
      count       <= 3'd0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      pop_valid_q <= (state == RD);
      if (push_acc) wdata_q <= bus.push_data;
      if (state == WR) begin
        wptr  <= wptr + 2'd1;
        count <= count + 3'd1;
      end
      if (state == RD) begin
        rptr    <= rptr + 2'd1;
        count   <= count - 3'd1;
        rdata_q <= bus.ram_rdata;
      end
    end
  end

  // The write strobe is decoded straight from the state so it falls as
  // soon as clear resets the state register.
  assign bus.ram_r_w    = (state == WR);
  assign bus.ram_addr   = (state == WR) ? wptr : rptr;
  assign bus.ram_wdata  = wdata_q;
  assign bus.pop_data   = rdata_q;
  assign bus.pop_valid  = pop_valid_q;
  assign bus.push_ready = push_rdy;
  assign bus.pop_ready  = pop_rdy;
  assign bus.full       = is_full;
  assign bus.empty      = is_empty;
  assign bus.count      = count;

endmodule

// File: tb/tb_fifo4x8_ctrl.sv
// Directed bench for fifo4x8_ctrl with a behavioural 4x8 RAM.
module tb_fifo4x8_ctrl;

  logic clk;
  logic clear;
  int   checks;
  int   failures;
  int   wr_cnt;
  logic [7:0] mem [4];

  fifo4x8_ctrl_if #(.WIDTH(8)) bus ();

  fifo4x8_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, asynchronous read.
  assign bus.ram_rdata = mem[bus.ram_addr];
  always @(posedge clk) begin
    if (bus.ram_r_w) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Starts just after a negedge; ends 1 time unit after a negedge in IDLE.
  task automatic push_op(input logic [7:0] d, output logic rdy,
                         output logic [1:0] addr, output logic rw,
                         output logic [7:0] wd);
    bus.push = 1'b1;
    bus.push_data = d;
    #1 rdy = bus.push_ready;
    @(posedge clk);
    @(negedge clk);
    bus.push = 1'b0;
    #1;
    rw = bus.ram_r_w; addr = bus.ram_addr; wd = bus.ram_wdata;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Ends 1 time unit after the negedge where pop_valid should be high.
  task automatic pop_op(output logic rdy, output logic [1:0] addr,
                        output logic rw, output logic pv_early,
                        output logic pv, output logic [7:0] pd);
    bus.pop = 1'b1;
    #1 rdy = bus.pop_ready;
    @(posedge clk);
    @(negedge clk);
    bus.pop = 1'b0;
    #1;
    rw = bus.ram_r_w; addr = bus.ram_addr; pv_early = bus.pop_valid;
    @(posedge clk);
    @(negedge clk);
    #1;
    pv = bus.pop_valid; pd = bus.pop_data;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 3'd0) begin
      failures++;
      $display("FAIL reset_flags: empty=%b full=%b count=%0d, want 1 0 0", bus.empty, bus.full, bus.count);
    end
    checks++;
    if (bus.push_ready !== 1'b1 || bus.pop_ready !== 1'b0 || bus.pop_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: push_ready=%b pop_ready=%b pop_valid=%b, want 1 0 0", bus.push_ready, bus.pop_ready, bus.pop_valid);
    end
    checks++;
    if (bus.pop_data !== 8'h00 || bus.ram_r_w !== 1'b0 || bus.ram_addr !== 2'd0 || bus.ram_wdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_ram: pop_data=%h r_w=%b addr=%0d wdata=%h, want 00 0 0 00", bus.pop_data, bus.ram_r_w, bus.ram_addr, bus.ram_wdata);
    end
    @(negedge clk);
    clear = 1'b1;
    #1;
  endtask

  task automatic test_fill();
    logic [7:0] d [4];
    logic rdy, rw; logic [1:0] addr; logic [7:0] wd;
    d[0] = 8'h03; d[1] = 8'h07; d[2] = 8'h0F; d[3] = 8'h1F;
    for (int i = 0; i < 4; i++) begin
      push_op(d[i], rdy, addr, rw, wd);
      checks++;
      if (rdy !== 1'b1 || rw !== 1'b1 || addr !== 2'(i) || wd !== d[i]) begin
        failures++;
        $display("FAIL fill_push%0d: ready=%b r_w=%b addr=%0d wdata=%h, want 1 1 %0d %h", i, rdy, rw, addr, wd, i, d[i]);
      end
      checks++;
      if (bus.count !== 3'(i + 1)) begin
        failures++;
        $display("FAIL fill_count%0d: count=%0d, want %0d", i, bus.count, i + 1);
      end
    end
    checks++;
    if (bus.full !== 1'b1 || bus.push_ready !== 1'b0 || wr_cnt !== 4) begin
      failures++;
      $display("FAIL fill_full: full=%b push_ready=%b writes=%0d, want 1 0 4", bus.full, bus.push_ready, wr_cnt);
    end
  endtask

  task automatic test_full_drain();
    logic [7:0] d [4];
    logic rdy, rw, pve, pv; logic [1:0] addr; logic [7:0] wd, pd;
    int w0;
    d[0] = 8'h03; d[1] = 8'h07; d[2] = 8'h0F; d[3] = 8'h1F;
    w0 = wr_cnt;
    push_op(8'hAA, rdy, addr, rw, wd);
    checks++;
    if (rdy !== 1'b0 || rw !== 1'b0 || bus.count !== 3'd4 || wr_cnt !== w0) begin
      failures++;
      $display("FAIL push_on_full: ready=%b r_w=%b count=%0d writes=%0d, want 0 0 4 %0d", rdy, rw, bus.count, wr_cnt, w0);
    end
    for (int i = 0; i < 4; i++) begin
      pop_op(rdy, addr, rw, pve, pv, pd);
      checks++;
      if (rdy !== 1'b1 || rw !== 1'b0 || addr !== 2'(i) || pve !== 1'b0) begin
        failures++;
        $display("FAIL drain_rd%0d: ready=%b r_w=%b addr=%0d early_valid=%b, want 1 0 %0d 0", i, rdy, rw, addr, pve, i);
      end
      checks++;
      if (pv !== 1'b1 || pd !== d[i]) begin
        failures++;
        $display("FAIL drain_data%0d: valid=%b data=%h, want 1 %h", i, pv, pd, d[i]);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.pop_valid !== 1'b0 || bus.pop_data !== 8'h1F || bus.empty !== 1'b1 || bus.count !== 3'd0) begin
      failures++;
      $display("FAIL drain_end: valid=%b data=%h empty=%b count=%0d, want 0 1f 1 0", bus.pop_valid, bus.pop_data, bus.empty, bus.count);
    end
    w0 = wr_cnt;
    pop_op(rdy, addr, rw, pve, pv, pd);
    checks++;
    if (rdy !== 1'b0 || rw !== 1'b0 || pve !== 1'b0 || pv !== 1'b0 || bus.count !== 3'd0 || wr_cnt !== w0) begin
      failures++;
      $display("FAIL pop_on_empty: ready=%b r_w=%b valid=%b/%b count=%0d, want 0 0 0/0 0", rdy, rw, pve, pv, bus.count);
    end
  endtask

  task automatic test_wrap();
    logic is_push [12];
    logic [7:0] q [$];
    logic [7:0] nd, exp;
    logic rdy, rw, pve, pv; logic [1:0] addr; logic [7:0] wd, pd;
    int wa, ra;
    is_push = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    nd = 8'h10; wa = 0; ra = 0;
    for (int i = 0; i < 12; i++) begin
      if (is_push[i]) begin
        push_op(nd, rdy, addr, rw, wd);
        checks++;
        if (rdy !== 1'b1 || rw !== 1'b1 || addr !== 2'(wa) || wd !== nd) begin
          failures++;
          $display("FAIL wrap_push%0d: ready=%b r_w=%b addr=%0d wdata=%h, want 1 1 %0d %h", i, rdy, rw, addr, wd, wa % 4, nd);
        end
        q.push_back(nd);
        nd = nd + 8'h01;
        wa = (wa + 1) % 4;
      end else begin
        exp = q.pop_front();
        pop_op(rdy, addr, rw, pve, pv, pd);
        checks++;
        if (rdy !== 1'b1 || addr !== 2'(ra) || pv !== 1'b1 || pd !== exp) begin
          failures++;
          $display("FAIL wrap_pop%0d: ready=%b addr=%0d valid=%b data=%h, want 1 %0d 1 %h", i, rdy, addr, pv, pd, ra, exp);
        end
        ra = (ra + 1) % 4;
      end
      checks++;
      if (bus.count !== 3'(q.size())) begin
        failures++;
        $display("FAIL wrap_count%0d: count=%0d, want %0d", i, bus.count, q.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic rdy, rw, pve, pv; logic [1:0] addr; logic [7:0] wd, pd;
    push_op(8'h55, rdy, addr, rw, wd);
    checks++;
    if (addr !== 2'd2 || bus.count !== 3'd1) begin
      failures++;
      $display("FAIL simul_setup: addr=%0d count=%0d, want 2 1", addr, bus.count);
    end
    bus.push = 1'b1; bus.pop = 1'b1; bus.push_data = 8'h66;
    #1;
    checks++;
    if (bus.pop_ready !== 1'b1 || bus.push_ready !== 1'b0) begin
      failures++;
      $display("FAIL simul_prio: pop_ready=%b push_ready=%b, want 1 0", bus.pop_ready, bus.push_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.pop = 1'b0;
    #1;
    checks++;
    if (bus.ram_r_w !== 1'b0 || bus.ram_addr !== 2'd2 || bus.push_ready !== 1'b0) begin
      failures++;
      $display("FAIL simul_rd: r_w=%b addr=%0d push_ready=%b, want 0 2 0", bus.ram_r_w, bus.ram_addr, bus.push_ready);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.pop_valid !== 1'b1 || bus.pop_data !== 8'h55 || bus.push_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_pop: valid=%b data=%h push_ready=%b, want 1 55 1", bus.pop_valid, bus.pop_data, bus.push_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.push = 1'b0;
    #1;
    checks++;
    if (bus.ram_r_w !== 1'b1 || bus.ram_addr !== 2'd3 || bus.ram_wdata !== 8'h66) begin
      failures++;
      $display("FAIL simul_wr: r_w=%b addr=%0d wdata=%h, want 1 3 66", bus.ram_r_w, bus.ram_addr, bus.ram_wdata);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.count !== 3'd1 || mem[3] !== 8'h66) begin
      failures++;
      $display("FAIL simul_end: count=%0d mem3=%h, want 1 66", bus.count, mem[3]);
    end
    pop_op(rdy, addr, rw, pve, pv, pd);
    checks++;
    if (addr !== 2'd3 || pv !== 1'b1 || pd !== 8'h66 || bus.count !== 3'd0) begin
      failures++;
      $display("FAIL simul_drain: addr=%0d valid=%b data=%h count=%0d, want 3 1 66 0", addr, pv, pd, bus.count);
    end
  endtask

  task automatic test_clear_abort();
    logic rdy, rw, pve, pv; logic [1:0] addr; logic [7:0] wd, pd;
    int w0;
    @(negedge clk);
    #1;
    w0 = wr_cnt;
    bus.push = 1'b1; bus.push_data = 8'h77;
    @(posedge clk);
    @(negedge clk);
    bus.push = 1'b0;
    #1;
    checks++;
    if (bus.ram_r_w !== 1'b1 || bus.ram_addr !== 2'd0) begin
      failures++;
      $display("FAIL clr_wr_setup: r_w=%b addr=%0d, want 1 0", bus.ram_r_w, bus.ram_addr);
    end
    #2 clear = 1'b0;
    #1;
    checks++;
    if (bus.ram_r_w !== 1'b0 || bus.count !== 3'd0 || bus.pop_ready !== 1'b0) begin
      failures++;
      $display("FAIL clr_wr_async: r_w=%b count=%0d pop_ready=%b, want 0 0 0", bus.ram_r_w, bus.count, bus.pop_ready);
    end
    @(negedge clk);
    clear = 1'b1;
    #1;
    checks++;
    if (bus.pop_ready !== 1'b0 || bus.empty !== 1'b1 || bus.push_ready !== 1'b1 || wr_cnt !== w0) begin
      failures++;
      $display("FAIL clr_wr_after: pop_ready=%b empty=%b push_ready=%b writes=%0d, want 0 1 1 %0d", bus.pop_ready, bus.empty, bus.push_ready, wr_cnt, w0);
    end
    push_op(8'h88, rdy, addr, rw, wd);
    checks++;
    if (rdy !== 1'b1 || rw !== 1'b1 || addr !== 2'd0 || bus.count !== 3'd1) begin
      failures++;
      $display("FAIL clr_first_push: ready=%b r_w=%b addr=%0d count=%0d, want 1 1 0 1", rdy, rw, addr, bus.count);
    end
    bus.pop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.pop = 1'b0;
    #1 clear = 1'b0;
    #1 clear = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.pop_valid !== 1'b0 || bus.pop_data !== 8'h00 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL clr_rd_abort: valid=%b data=%h count=%0d empty=%b, want 0 00 0 1", bus.pop_valid, bus.pop_data, bus.count, bus.empty);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    wr_cnt = 0;
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    test_reset();
    test_fill();
    test_full_drain();
    test_wrap();
    test_back_to_back();
    test_clear_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo4x8_ctrl.md
FIFO4X8_CTRL -- requirements
Module: fifo4x8_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, data width of push/pop/RAM data buses; fixed at 8 for the 4x8 RAM.
REQ-002 clk  input  1  system clock; all state changes on posedge.
REQ-003 clear  input  1  reset, asynchronous, active-low.
REQ-004 push  input  1  producer requests a write of push_data.
REQ-005 push_data  input  8  word to enqueue.
REQ-006 push_ready  output  1  push accepted this cycle when push & push_ready.
REQ-007 pop  input  1  consumer requests a read.
REQ-008 pop_ready  output  1  pop accepted this cycle when pop & pop_ready.
REQ-009 pop_data  output  8  dequeued word, valid while pop_valid.
REQ-010 pop_valid  output  1  one-cycle pulse marking pop_data.
REQ-011 full  output  1  count == 4.
REQ-012 empty  output  1  count == 0.
REQ-013 count  output  3  entries held, 0..4.
REQ-014 ram_addr  output  2  address to downstream 4x8 RAM.
REQ-015 ram_r_w  output  1  1 = write strobe to RAM, 0 = read.
REQ-016 ram_wdata  output  8  write data to RAM.
REQ-017 ram_rdata  input  8  read data from RAM.

Function
REQ-018 The block SHALL be a 4-entry x 8-bit FIFO controller using the external 4x8 RAM as storage, one RAM access per cycle.
REQ-019 The block SHALL implement a state machine with states IDLE, WR, RD; handshakes are accepted only in IDLE.
REQ-020 Readiness: pop_ready = IDLE & ~empty; push_ready = IDLE & ~full & ~(pop & ~empty), so pop has priority on simultaneous requests.
REQ-021 Push accepted in cycle N: the block SHALL latch push_data into ram_wdata and go to WR; in N+1 it drives ram_r_w=1, ram_addr=wptr; at end of N+1 wptr+1 (mod 4), count+1, return to IDLE.
REQ-022 Pop accepted in cycle N: the block SHALL go to RD; in N+1 it drives ram_r_w=0, ram_addr=rptr and samples ram_rdata into pop_data at end of N+1; rptr+1 (mod 4), count-1; pop_valid=1 during N+2 only; return to IDLE.
REQ-023 ram_r_w SHALL be 1 only in WR; in IDLE and RD it is 0, and ram_addr holds rptr in IDLE.
REQ-024 Pointers SHALL be 2-bit and wrap 3->0; full/empty derive from count, never from pointer comparison.
REQ-025 Push while full or pop while empty SHALL be ignored: no state, pointer, count or RAM change.
REQ-026 pop_data SHALL hold its last value when pop_valid is 0.
REQ-027 Maximum throughput: one operation per 2 cycles; a new handshake may be accepted in the cycle pop_valid is high.

Reset
REQ-028 While clear=0, asynchronously: state IDLE, wptr=rptr=0, count=0, empty=1, full=0, push_ready=0 only if... held at IDLE&~full (=1), pop_ready=0, pop_valid=0, pop_data=0, ram_r_w=0, ram_addr=0, ram_wdata=0.
REQ-029 Reset asserted in WR or RD SHALL abort the access: ram_r_w drops to 0 immediately, no pointer/count update, no pop_valid pulse.
REQ-030 After clear returns to 1, the first handshake SHALL be accepted on the next posedge.

Verification
REQ-031 Reset then push 8'h03, 8'h07, 8'h0F, 8'h1F -> RAM writes at addr 0,1,2,3 with ram_r_w=1 one cycle each; count 4, full=1, push_ready=0.
REQ-032 From full, push 8'hAA -> ignored; pops return 8'h03, 8'h07, 8'h0F, 8'h1F in order, pop_valid 2 cycles after each accept; empty=1 at end.
REQ-033 Wrap: push/pop 6 words 8'h10..8'h15 keeping count<=2 -> addresses wrap 3->0, data returned in order.
REQ-034 Simultaneous push and pop with count=1 -> pop accepted, push_ready=0 that cycle; push accepted in next IDLE; count back to 1.
REQ-035 Pop on empty and push on full -> no RAM strobe, count unchanged, pop_valid stays 0.
REQ-036 clear=0 asserted during WR -> ram_r_w falls without waiting for clk, count=0, subsequent pop_ready=0.
